// File: rtl/vga_pkg.sv
// Shared VGA geometry, paddle/ball constants and the ball FSM state type used
// by the paddle and ball stages of the Pong video chain.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam int BALL_SIZE  = 16;
  localparam int PAD_HEIGHT = 100;
  localparam int PAD_WIDTH  = 15;
  localparam int PAD_L_X    = 30;
  localparam int PAD_R_X    = HOR_PIXELS - 45;

  typedef enum logic [1:0] {IDLE, PLAY, SCORED} ball_state_t;

  // True when v lies in [lo, lo+len-1]; widened by one bit so lo+len cannot wrap.
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo, input int len);
    logic [11:0] hi;
    hi = {1'b0, lo} + 12'(len - 1);
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} <= hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + pixel bundle passed between stages of the video chain.
interface vga_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/ball_phys.sv
// Ball physics: frame tick detection, serve latch, IDLE/PLAY/SCORED FSM,
// per-frame motion with wall/paddle bounces and miss detection.
module ball_phys #(
  parameter int BALL_SIZE   = vga_pkg::BALL_SIZE,
  parameter int SPEED       = 6,
  parameter int PAD_HEIGHT  = vga_pkg::PAD_HEIGHT,
  parameter int PAD_WIDTH   = vga_pkg::PAD_WIDTH,
  parameter int PAD_L_X     = vga_pkg::PAD_L_X,
  parameter int PAD_R_X     = vga_pkg::PAD_R_X,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serve,
  input  logic                vblnk,
  input  logic [10:0]         y_pad_left,
  input  logic [10:0]         y_pad_right,
  output logic [10:0]         ball_x,
  output logic [10:0]         ball_y,
  output logic                score_left,
  output logic                score_right,
  output vga_pkg::ball_state_t state
);
  import vga_pkg::*;

  localparam logic [11:0] HOR    = 12'(HOR_PIXELS);
  localparam logic [11:0] VER    = 12'(VER_PIXELS);
  localparam logic [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic [11:0] SPD    = 12'(SPEED);
  localparam logic [11:0] PH     = 12'(PAD_HEIGHT);
  localparam logic [11:0] PW     = 12'(PAD_WIDTH);
  localparam logic [11:0] PLX    = 12'(PAD_L_X);
  localparam logic [11:0] PRX    = 12'(PAD_R_X);
  localparam logic [11:0] X_HOME = 12'((HOR_PIXELS - BALL_SIZE) / 2);
  localparam logic [11:0] Y_HOME = 12'((VER_PIXELS - BALL_SIZE) / 2);

  localparam int                HOLD_W    = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [11:0]       x, y;
  logic              dir_x;   // 1 = moving right
  logic              dir_y;   // 1 = moving down
  logic              vblnk_q;
  logic              serve_pend;
  logic [HOLD_W-1:0] hold_cnt;
  logic              frame_tick;

  logic [11:0] ypl, ypr, nx, ny, nx_res, ny_res;
  logic        ndx, ndy, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  assign frame_tick = vblnk & ~vblnk_q;
  assign ball_x     = x[10:0];
  assign ball_y     = y[10:0];

  // Next position with both axes resolved independently; a wall and a paddle
  // in the same tick therefore flip both direction bits.
  always_comb begin
    ypl    = {1'b0, y_pad_left};
    ypr    = {1'b0, y_pad_right};
    nx     = dir_x ? x + SPD : x - SPD;
    ny     = dir_y ? y + SPD : y - SPD;
    ny_res = ny;
    ndy    = dir_y;
    if (!dir_y && (y < SPD)) begin
      ny_res = '0;
      ndy    = 1'b1;
    end else if (dir_y && (y + BSZ + SPD > VER)) begin
      ny_res = VER - BSZ;
      ndy    = 1'b0;
    end
    ovl_l  = (y + BSZ - 12'd1 >= ypl) && (y <= ypl + PH);
    ovl_r  = (y + BSZ - 12'd1 >= ypr) && (y <= ypr + PH);
    hit_l  = !dir_x && (nx <= PLX + PW) && (x > PLX) && ovl_l;
    hit_r  = dir_x && (nx + BSZ - 12'd1 >= PRX) && (x + BSZ - 12'd1 < PRX + PW) && ovl_r;
    miss_l = !dir_x && (x < SPD) && !hit_l;
    miss_r = dir_x && (x + BSZ + SPD > HOR) && !hit_r;
    nx_res = nx;
    ndx    = dir_x;
    if (hit_l) begin
      nx_res = PLX + PW + 12'd1;
      ndx    = 1'b1;
    end else if (hit_r) begin
      nx_res = PRX - BSZ;
      ndx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= X_HOME;
      y           <= Y_HOME;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      vblnk_q     <= 1'b0;
      serve_pend  <= 1'b0;
      hold_cnt    <= '0;
      score_left  <= 1'b0;
      score_right <= 1'b0;
    end else begin
      vblnk_q     <= vblnk;
      score_left  <= 1'b0;
      score_right <= 1'b0;
      if (frame_tick) begin
        case (state)
          IDLE: begin
            if (serve_pend) begin
              state      <= PLAY;
              serve_pend <= 1'b0;
            end
          end
          PLAY: begin
            // On a miss the ball freezes where it left the field.
            if (miss_l || miss_r) begin
              state       <= SCORED;
              score_right <= miss_l;
              score_left  <= miss_r;
            end else begin
              x     <= nx_res;
              y     <= ny_res;
              dir_x <= ndx;
              dir_y <= ndy;
            end
          end
          SCORED: begin
            // dir_x already points at the side that conceded, so it is kept.
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              x        <= X_HOME;
              y        <= Y_HOME;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (serve) serve_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/ball_ctl.sv
// Pong ball stage: runs the ball physics and overlays the ball square onto the
// incoming VGA stream with a one-cycle pipeline delay.
module ball_ctl #(
  parameter int          BALL_SIZE   = vga_pkg::BALL_SIZE,
  parameter int          SPEED       = 6,
  parameter int          PAD_HEIGHT  = vga_pkg::PAD_HEIGHT,
  parameter int          PAD_WIDTH   = vga_pkg::PAD_WIDTH,
  parameter int          PAD_L_X     = vga_pkg::PAD_L_X,
  parameter int          PAD_R_X     = vga_pkg::PAD_R_X,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [11:0] BALL_COLOR  = 12'hff0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serve,
  input  logic [10:0] y_pad_left,
  input  logic [10:0] y_pad_right,
  vga_if.in           vga,
  vga_if.out          vga_out,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        score_left,
  output logic        score_right
);
  import vga_pkg::*;

  ball_state_t state;
  logic        in_ball;
  logic [11:0] rgb_nxt;

  ball_phys #(
    .BALL_SIZE   (BALL_SIZE),
    .SPEED       (SPEED),
    .PAD_HEIGHT  (PAD_HEIGHT),
    .PAD_WIDTH   (PAD_WIDTH),
    .PAD_L_X     (PAD_L_X),
    .PAD_R_X     (PAD_R_X),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_phys (
    .clk         (clk),
    .rst         (rst),
    .serve       (serve),
    .vblnk       (vga.vblnk),
    .y_pad_left  (y_pad_left),
    .y_pad_right (y_pad_right),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score_left  (score_left),
    .score_right (score_right),
    .state       (state)
  );

  always_comb begin
    in_ball = (state != SCORED)
              && in_span(vga.hcount, ball_x, BALL_SIZE)
              && in_span(vga.vcount, ball_y, BALL_SIZE);
    rgb_nxt = in_ball ? BALL_COLOR : vga.rgb;
  end

  // Stage p1: every VGA field delayed by one cycle, rgb with the ball overlaid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= vga.hcount;
      vga_out.vcount <= vga.vcount;
      vga_out.hsync  <= vga.hsync;
      vga_out.hblnk  <= vga.hblnk;
      vga_out.vsync  <= vga.vsync;
      vga_out.vblnk  <= vga.vblnk;
      vga_out.rgb    <= rgb_nxt;
    end
  end

endmodule
